// File: rtl/nq_multiplier_axi4s_client_if.sv
// Bundled request, AXI4-S operand/product and result signals of the N/Q multiplier client.
// master = the client engine, slave = the environment that drives it.
interface nq_multiplier_axi4s_client_if #(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ID_WIDTH_P   = 4,
    parameter int N_BITS_P         = 16
);
    logic                        req_valid;
    logic                        req_ready;
    logic [N_BITS_P-1:0]         req_multiplicand;
    logic [N_BITS_P-1:0]         req_multiplier;
    logic [AXI_ID_WIDTH_P-1:0]   req_id;

    logic                        mul_tvalid;
    logic                        mul_tready;
    logic [AXI_DATA_WIDTH_P-1:0] mul_tdata;
    logic                        mul_tlast;
    logic [AXI_ID_WIDTH_P-1:0]   mul_tid;

    logic                        rsp_tvalid;
    logic [AXI_DATA_WIDTH_P-1:0] rsp_tdata;
    logic                        rsp_tlast;
    logic [AXI_ID_WIDTH_P-1:0]   rsp_tid;
    logic                        rsp_tuser;

    logic                        res_valid;
    logic                        res_ready;
    logic [N_BITS_P-1:0]         res_product;
    logic                        res_overflow;
    logic [AXI_ID_WIDTH_P-1:0]   res_id;
    logic [1:0]                  res_error;
    logic                        stray_rsp;

    modport master (
        input  req_valid, req_multiplicand, req_multiplier, req_id,
        output req_ready,
        output mul_tvalid, mul_tdata, mul_tlast, mul_tid,
        input  mul_tready,
        input  rsp_tvalid, rsp_tdata, rsp_tlast, rsp_tid, rsp_tuser,
        output res_valid, res_product, res_overflow, res_id, res_error,
        input  res_ready,
        output stray_rsp
    );

    modport slave (
        output req_valid, req_multiplicand, req_multiplier, req_id,
        input  req_ready,
        input  mul_tvalid, mul_tdata, mul_tlast, mul_tid,
        output mul_tready,
        output rsp_tvalid, rsp_tdata, rsp_tlast, rsp_tid, rsp_tuser,
        input  res_valid, res_product, res_overflow, res_id, res_error,
        output res_ready,
        input  stray_rsp
    );
endinterface

// File: rtl/nq_multiplier_axi4s_client.sv
// Requester engine: sends an operand pair as a two-beat AXI4-S packet, awaits the
// single-beat product with ID check and timeout, and holds the result until consumed.
module nq_multiplier_axi4s_client #(
    parameter int AXI_DATA_WIDTH_P = 32,
    parameter int AXI_ID_WIDTH_P   = 4,
    parameter int N_BITS_P         = 16,
    parameter int TIMEOUT_P        = 64
) (
    input logic clk,
    input logic rst_n,
    nq_multiplier_axi4s_client_if.master bus
);
    localparam int CNT_W = (TIMEOUT_P > 2) ? $clog2(TIMEOUT_P) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_A   = 3'd1,
        SEND_B   = 3'd2,
        WAIT_RSP = 3'd3,
        HOLD     = 3'd4
    } state_t;

    state_t                        state_q;
    state_t                        state_d;
    logic                          alive_q;
    logic signed [N_BITS_P-1:0]    mcand_p0;
    logic signed [N_BITS_P-1:0]    mplier_p0;
    logic [AXI_ID_WIDTH_P-1:0]     id_p0;
    logic [CNT_W-1:0]              cnt_q;
    logic [N_BITS_P-1:0]           product_p1;
    logic                          overflow_p1;
    logic [1:0]                    error_p1;
    logic                          stray_q;
    logic                          accept;
    logic                          rsp_hit;
    logic                          timeout_hit;
    logic                          unused_ok;

    function automatic logic signed [AXI_DATA_WIDTH_P-1:0] sext(
        input logic signed [N_BITS_P-1:0] v
    );
        return AXI_DATA_WIDTH_P'(v);
    endfunction

    // Only the low N_BITS_P of the product are meaningful; tlast carries nothing here.
    assign unused_ok   = ^{bus.rsp_tlast, bus.rsp_tdata};

    assign accept      = bus.req_valid && alive_q && (state_q == IDLE);
    assign rsp_hit     = (state_q == WAIT_RSP) && bus.rsp_tvalid;
    // A response in the final waiting cycle takes priority over the timeout.
    assign timeout_hit = (state_q == WAIT_RSP) && !bus.rsp_tvalid &&
                         (cnt_q == CNT_W'(TIMEOUT_P - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept)                   state_d = SEND_A;
            SEND_A:   if (bus.mul_tready)           state_d = SEND_B;
            SEND_B:   if (bus.mul_tready)           state_d = WAIT_RSP;
            WAIT_RSP: if (rsp_hit || timeout_hit)   state_d = HOLD;
            HOLD:     if (bus.res_ready)            state_d = IDLE;
            default:                                state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = alive_q && (state_q == IDLE);
        bus.mul_tvalid   = (state_q == SEND_A) || (state_q == SEND_B);
        bus.mul_tlast    = (state_q == SEND_B);
        bus.mul_tdata    = '0;
        bus.mul_tid      = '0;
        if (state_q == SEND_A) begin
            bus.mul_tdata = sext(mcand_p0);
            bus.mul_tid   = id_p0;
        end else if (state_q == SEND_B) begin
            bus.mul_tdata = sext(mplier_p0);
            bus.mul_tid   = id_p0;
        end
        bus.res_valid    = (state_q == HOLD);
        bus.res_product  = product_p1;
        bus.res_overflow = overflow_p1;
        bus.res_id       = id_p0;
        bus.res_error    = error_p1;
        bus.stray_rsp    = stray_q;
    end

    // Stage p0: operand and ID capture at request acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_p0  <= '0;
            mplier_p0 <= '0;
            id_p0     <= '0;
        end else if (accept) begin
            mcand_p0  <= bus.req_multiplicand;
            mplier_p0 <= bus.req_multiplier;
            id_p0     <= bus.req_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_q == SEND_B) && bus.mul_tready) begin
            cnt_q <= '0;
        end else if (state_q == WAIT_RSP) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Stage p1: result capture from response or timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_p1  <= '0;
            overflow_p1 <= 1'b0;
            error_p1    <= 2'b00;
        end else if (rsp_hit) begin
            product_p1  <= bus.rsp_tdata[N_BITS_P-1:0];
            overflow_p1 <= bus.rsp_tuser;
            error_p1    <= {bus.rsp_tid != id_p0, 1'b0};
        end else if (timeout_hit) begin
            product_p1  <= '0;
            overflow_p1 <= 1'b0;
            error_p1    <= 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stray_q <= 1'b0;
        end else begin
            stray_q <= bus.rsp_tvalid && (state_q != WAIT_RSP);
        end
    end
endmodule

// File: doc/nq_multiplier_axi4s_client.md
# nq_multiplier_axi4s_client

Requester-side engine for the fixed-point N/Q multiplier's AXI4-S service. It accepts one operand pair per request on a local valid/ready port and serializes it into a two-beat AXI4-S packet: multiplicand first, then multiplier with tlast. It then waits for the single-beat product response, checks its ID and applies a timeout. The result, overflow flag and error status are presented on a held valid/ready result port. One request is outstanding at a time.

## Interface
- AXI_DATA_WIDTH_P, -1, AXI4-S tdata width; must be >= N_BITS_P
- AXI_ID_WIDTH_P, -1, tid width
- N_BITS_P, -1, operand/product width
- TIMEOUT_P, 64, cycles allowed in WAIT_RSP before declaring timeout (>= 2)
- clk  input  1  clock
- rst_n  input  1  one clock; reset is asynchronous and active-low
- req_valid  input  1  operand pair valid
- req_ready  output  1  high only in IDLE
- req_multiplicand  input  N_BITS_P  first operand
- req_multiplier  input  N_BITS_P  second operand
- req_id  input  AXI_ID_WIDTH_P  transaction ID
- mul_tvalid  output  1  AXI4-S beat valid
- mul_tready  input  1  multiplier ready
- mul_tdata  output  AXI_DATA_WIDTH_P  operand, sign-extended from N_BITS_P
- mul_tlast  output  1  0 on multiplicand beat, 1 on multiplier beat
- mul_tid  output  AXI_ID_WIDTH_P  latched req_id on both beats
- rsp_tvalid  input  1  product valid; no back-pressure exists, so it is always accepted
- rsp_tdata  input  AXI_DATA_WIDTH_P  product in bits [N_BITS_P-1:0]
- rsp_tlast  input  1  ignored
- rsp_tid  input  AXI_ID_WIDTH_P  response ID
- rsp_tuser  input  1  overflow flag
- res_valid  output  1  result held
- res_ready  input  1  result consumed
- res_product  output  N_BITS_P  product, or 0 on timeout
- res_overflow  output  1  captured rsp_tuser, or 0 on timeout
- res_id  output  AXI_ID_WIDTH_P  latched req_id
- res_error  output  2  bit0 = timeout, bit1 = ID mismatch
- stray_rsp  output  1  one-cycle pulse when rsp_tvalid arrives outside WAIT_RSP

## Operation
- FSM states: IDLE, SEND_A, SEND_B, WAIT_RSP, HOLD.
- IDLE: req_ready = 1. On req_valid: latch operands and req_id, then go to SEND_A.
- SEND_A: mul_tvalid = 1, mul_tdata = sext(multiplicand), mul_tlast = 0. On mul_tready, go to SEND_B.
- SEND_B: mul_tvalid = 1, mul_tdata = sext(multiplier), mul_tlast = 1. On mul_tready, go to WAIT_RSP and clear the timeout counter.
- mul_tdata, mul_tlast and mul_tid stay stable while mul_tvalid && !mul_tready.
- WAIT_RSP: the counter increments every cycle.
  - On rsp_tvalid: capture rsp_tdata[N_BITS_P-1:0] and rsp_tuser; set res_error[1] = (rsp_tid != latched ID); go to HOLD.
  - Otherwise, when the counter == TIMEOUT_P-1: res_product = 0, res_overflow = 0, res_error = 2'b01, go to HOLD.
  - If rsp_tvalid arrives in the timeout cycle, the response wins and timeout is not flagged.
- HOLD: res_valid = 1 and all res_* outputs are stable. On res_ready, go to IDLE. The next request can be accepted no earlier than the following cycle.
- A response arriving in IDLE, SEND_A, SEND_B or HOLD (for example a late response after a timeout) is dropped; stray_rsp pulses and no state changes.
- Reset, including mid-packet: all outputs 0, state IDLE, counter 0, latched fields 0. A partially sent packet is abandoned.

## Timing
- Reset values: req_ready = 0 while rst_n is low and 1 from the first clock after release; mul_tvalid, mul_tdata, mul_tlast, mul_tid, res_* and stray_rsp are 0.
- Request accepted at edge T: mul_tvalid is high from T+1. With mul_tready held high, the beats occur at T+1 and T+2, and the state is WAIT_RSP from T+3.
- Response at cycle R: res_valid rises at R+1.
- Timeout: res_valid rises exactly TIMEOUT_P cycles after entering WAIT_RSP.
- Minimum request-to-request period with zero-wait handshakes and an immediate response: 5 cycles.
- res_valid is registered; req_ready and mul_tvalid are decoded from the registered state only.

## Test plan
- Parameters N=16, Q=8, ID=4: request 0x0180 × 0x0200, id=3. Required: beats 0x0180 (tlast=0), 0x0200 (tlast=1), tid=3. Model responds 0x0300, tid=3, tuser=0 → res_product=0x0300, res_id=3, res_error=0.
- mul_tready low for 5 cycles on each beat: tdata, tlast and tid stay stable. Exactly two beats are transferred.
- Withhold the response: res_error=2'b01 and res_product=0 exactly 64 cycles after WAIT_RSP entry. A response sent afterwards pulses stray_rsp and leaves res_* unchanged.
- Response with tid=5 for request id=3 and tuser=1 → res_error=2'b10, res_overflow=1, res_id=3.
- Response in the exact timeout cycle → captured product, res_error=0.
- Assert rst_n low during SEND_B → mul_tvalid=0 asynchronously. After release, a new request (0xFF00 × 0x0100, id=1) completes with beat 1 data 0xFF00 sign-extended into the upper tdata bits.
